// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : seven_seg_scan_ctrl_if
// Brief  : Host-side write/commit bus of the seven-segment scan controller.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface seven_seg_scan_ctrl_if;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic       commit_req;
   logic       commit_pending;
   logic       commit_done;

   modport master (
      output wr_en, wr_addr, wr_data, commit_req,
      input  commit_pending, commit_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit_req,
      output commit_pending, commit_done
   );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : seven_seg_scan_ctrl
// Brief  : 8-digit display scanner with double-buffered digit registers.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
   parameter int CLK_DIV = 100000
) (
   input  wire logic           clk,
   input  wire logic           rst,
   seven_seg_scan_ctrl_if.slave bus,
   input  wire logic [7:0]     digit_en,
   output logic      [3:0]     num,
   output logic      [2:0]     sel,
   output logic                blank,
   output logic                frame_tick
);

   localparam int                 c_cnt_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(CLK_DIV - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ARMED = 1'b1
   } state_t;

   state_t             r_state;
   logic [c_cnt_w-1:0] r_div_cnt;
   logic [2:0]         r_sel;
   logic [7:0][3:0]    r_shadow;
   logic [7:0][3:0]    r_active;
   logic               r_commit_done;
   logic               r_frame_tick;
   logic               w_slot_tick;
   logic               w_wrap;

   assign w_slot_tick = (r_div_cnt == c_div_last);
   assign w_wrap      = w_slot_tick && (r_sel == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_sel     <= '0;
      end else if (w_slot_tick) begin
         r_div_cnt <= '0;
         r_sel     <= r_sel + 3'd1;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow <= '0;
      end else if (bus.wr_en) begin
         r_shadow[bus.wr_addr] <= bus.wr_data;
      end
   end

   // The copy reads r_shadow before this edge, so a write on the commit edge waits for the next commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_active      <= '0;
         r_commit_done <= 1'b0;
         r_frame_tick  <= 1'b0;
      end else begin
         r_commit_done <= 1'b0;
         r_frame_tick  <= w_wrap;
         case (r_state)
            S_IDLE: begin
               if (bus.commit_req) r_state <= S_ARMED;
            end
            S_ARMED: begin
               if (w_wrap) begin
                  r_active      <= r_shadow;
                  r_commit_done <= 1'b1;
                  if (!bus.commit_req) r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sel                = r_sel;
   assign num                = r_active[r_sel];
   assign blank              = ~digit_en[r_sel];
   assign frame_tick         = r_frame_tick;
   assign bus.commit_pending = (r_state == S_ARMED);
   assign bus.commit_done    = r_commit_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_seven_seg_scan_ctrl
// Brief  : Directed self-checking bench, CLK_DIV=4 and CLK_DIV=1 instances.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       rst1;
   logic [7:0] digit_en;
   logic [7:0] digit_en1;

   logic [3:0] num4, num1;
   logic [2:0] sel4, sel1;
   logic       blank4, blank1;
   logic       ft4, ft1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   seven_seg_scan_ctrl_if bus4 ();
   seven_seg_scan_ctrl_if bus1 ();

   seven_seg_scan_ctrl #(.CLK_DIV(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus4),
      .digit_en   (digit_en),
      .num        (num4),
      .sel        (sel4),
      .blank      (blank4),
      .frame_tick (ft4)
   );

   seven_seg_scan_ctrl #(.CLK_DIV(1)) dut1 (
      .clk        (clk),
      .rst        (rst1),
      .bus        (bus1),
      .digit_en   (digit_en1),
      .num        (num1),
      .sel        (sel1),
      .blank      (blank1),
      .frame_tick (ft1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic advance_to(input int target);
      while (cyc < target) tick();
   endtask

   initial begin
      rst             = 1'b1;
      rst1            = 1'b1;
      digit_en        = 8'hFF;
      digit_en1       = 8'hFF;
      bus4.wr_en      = 1'b0;
      bus4.wr_addr    = '0;
      bus4.wr_data    = '0;
      bus4.commit_req = 1'b0;
      bus1.wr_en      = 1'b0;
      bus1.wr_addr    = '0;
      bus1.wr_data    = '0;
      bus1.commit_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;

      // 1: reset state and free-running scan
      check("rst_sel", sel4, 0);
      check("rst_num", num4, 0);
      check("rst_blank", blank4, 0);
      check("rst_pending", bus4.commit_pending, 0);
      check("rst_done", bus4.commit_done, 0);
      check("rst_ft", ft4, 0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         check("t1_sel", sel4, (k / 4) % 8);
         check("t1_num", num4, 0);
         check("t1_blank", blank4, 0);
         check("t1_ft", ft4, (k == 32) ? 1 : 0);
      end

      // 2: fill shadow, commit requested mid-frame
      for (int i = 0; i < 8; i++) begin
         bus4.wr_en   = 1'b1;
         bus4.wr_addr = 3'(i);
         bus4.wr_data = 4'(i + 8);
         tick();
      end
      bus4.wr_en = 1'b0;
      advance_to(44);
      check("t2_sel3", sel4, 3);
      bus4.commit_req = 1'b1;
      tick();
      bus4.commit_req = 1'b0;
      check("t2_pending", bus4.commit_pending, 1);
      check("t2_num_pre", num4, 0);
      advance_to(63);
      check("t2_num_last", num4, 0);
      check("t2_done_early", bus4.commit_done, 0);
      tick();
      check("t2_wrap_sel", sel4, 0);
      check("t2_wrap_num", num4, 8);
      check("t2_done", bus4.commit_done, 1);
      check("t2_ft", ft4, 1);
      check("t2_pending_clr", bus4.commit_pending, 0);
      tick();
      check("t2_done_once", bus4.commit_done, 0);
      check("t2_ft_once", ft4, 0);
      for (int s = 1; s < 8; s++) begin
         advance_to(64 + 4 * s);
         check("t2_scan_sel", sel4, s);
         check("t2_scan_num", num4, s + 8);
      end

      // 3: write and re-request on the committing wrap edge
      bus4.commit_req = 1'b1;
      tick();
      bus4.commit_req = 1'b0;
      check("t3_armed", bus4.commit_pending, 1);
      advance_to(95);
      bus4.wr_en      = 1'b1;
      bus4.wr_addr    = 3'd5;
      bus4.wr_data    = 4'hA;
      bus4.commit_req = 1'b1;
      tick();
      bus4.wr_en      = 1'b0;
      bus4.commit_req = 1'b0;
      check("t3_done1", bus4.commit_done, 1);
      check("t3_ft", ft4, 1);
      check("t3_still_armed", bus4.commit_pending, 1);
      advance_to(116);
      check("t3_sel5", sel4, 5);
      check("t3_old_digit5", num4, 4'hD);
      advance_to(127);
      check("t3_done_gap", bus4.commit_done, 0);
      tick();
      check("t3_done2", bus4.commit_done, 1);
      check("t3_idle", bus4.commit_pending, 0);
      advance_to(148);
      check("t3_new_digit5", num4, 4'hA);

      // 4: live digit enables
      digit_en = 8'b1010_1010;
      #1;
      check("t4_blank_s5", blank4, 0);
      check("t4_num_s5", num4, 4'hA);
      advance_to(152);
      check("t4_blank_s6", blank4, 1);
      check("t4_num_s6", num4, 4'hE);
      advance_to(156);
      check("t4_blank_s7", blank4, 0);
      check("t4_num_s7", num4, 4'hF);
      advance_to(160);
      check("t4_blank_s0", blank4, 1);
      check("t4_num_s0", num4, 4'h8);
      advance_to(164);
      check("t4_blank_s1", blank4, 0);
      advance_to(168);
      check("t4_sel2", sel4, 2);
      check("t4_blank_s2", blank4, 1);
      digit_en[2] = 1'b1;
      #1;
      check("t4_blank_on", blank4, 0);
      check("t4_num_s2", num4, 4'hA);
      digit_en[2] = 1'b0;
      #1;
      check("t4_blank_off", blank4, 1);

      // 5: asynchronous reset while a commit is armed
      advance_to(184);
      check("t5_sel6", sel4, 6);
      bus4.commit_req = 1'b1;
      tick();
      bus4.commit_req = 1'b0;
      check("t5_pending", bus4.commit_pending, 1);
      advance_to(189);
      check("t5_sel7", sel4, 7);
      rst = 1'b1;
      #1;
      check("t5_async_sel", sel4, 0);
      check("t5_async_num", num4, 0);
      check("t5_async_pending", bus4.commit_pending, 0);
      check("t5_async_done", bus4.commit_done, 0);
      check("t5_async_ft", ft4, 0);
      check("t5_async_blank", blank4, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      for (int s = 0; s < 8; s++) begin
         advance_to(4 * s);
         check("t5_post_sel", sel4, s);
         check("t5_post_num", num4, 0);
      end
      advance_to(32);
      check("t5_no_done", bus4.commit_done, 0);
      check("t5_ft", ft4, 1);
      check("t5_num_zero", num4, 0);

      // 6: CLK_DIV=1 instance
      rst1 = 1'b0;
      cyc  = 0;
      check("t6_rst_sel", sel1, 0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("t6_sel", sel1, k % 8);
         check("t6_ft", ft1, (k % 8 == 0) ? 1 : 0);
      end
      bus1.wr_en   = 1'b1;
      bus1.wr_addr = 3'd7;
      bus1.wr_data = 4'h3;
      tick();
      bus1.wr_en = 1'b0;
      advance_to(22);
      bus1.commit_req = 1'b1;
      tick();
      bus1.commit_req = 1'b0;
      check("t6_sel7", sel1, 7);
      check("t6_pending", bus1.commit_pending, 1);
      check("t6_num_pre", num1, 0);
      tick();
      check("t6_done", bus1.commit_done, 1);
      check("t6_pending_clr", bus1.commit_pending, 0);
      check("t6_wrap_sel", sel1, 0);
      advance_to(31);
      check("t6_num7", num1, 4'h3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing scan controller for the 8-digit seven-segment display. It holds eight 4-bit digit values in a double-buffered register file and steps the digit select through all eight positions at a programmable rate. It drives the `num`/`sel` inputs of the seven-segment decoder, plus a per-digit blank flag. Host writes go to a shadow bank and are committed to the displayed bank only at a frame boundary, so a partial update is never shown.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot; legal range ≥1. Counter width is max(1, $clog2(CLK_DIV)).
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: write strobe to the shadow bank.
- `wr_addr`  in  3: shadow digit index, 0–7.
- `wr_data`  in  4: hex value written.
- `commit_req`  in  1: request to copy shadow to active at the next frame boundary.
- `digit_en`  in  8: per-digit enable; 0 blanks that digit. Used live, not buffered.
- `num`  out  4: active value of the currently selected digit; goes to the decoder `num` input.
- `sel`  out  3: current digit index; goes to the decoder `sel` input.
- `blank`  out  1: high when the current digit is disabled; the top level forces anodes all-ones while it is high.
- `commit_pending`  out  1: a commit is armed and not yet applied.
- `commit_done`  out  1: one-cycle pulse after the shadow-to-active copy.
- `frame_tick`  out  1: one-cycle pulse when `sel` wraps from 7 to 0.

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps. `slot_tick` = (`div_cnt` == CLK_DIV-1). With CLK_DIV=1, `slot_tick` is high every cycle.
- On `slot_tick`, `sel` <= `sel`+1 (mod 8). `sel` is registered.
- `num` = active[`sel`], combinational from registered state. `blank` = ~`digit_en`[`sel`], combinational.
- Write: when `wr_en` is high, shadow[`wr_addr`] <= `wr_data` on the clock edge. The active bank is never written directly.
- Commit FSM, states IDLE and ARMED (`commit_pending` = ARMED):
  - IDLE -> ARMED when `commit_req` is high.
  - ARMED -> IDLE on a wrap edge (`slot_tick` && `sel`==7). On that edge, active <= shadow for all 8 digits, and `commit_done` is 1 in the following cycle.
  - A `commit_req` while ARMED is absorbed, with no extra commit.
  - If `commit_req` is high on the wrap edge that commits, the state stays ARMED for the next frame.
- Copy uses shadow values from before the edge. A `wr_en` on the commit edge lands in shadow only and is shown after the next commit.
- `frame_tick` is registered and is 1 in the cycle after the wrap edge, aligned with `sel`==0 and `commit_done`.

## Timing
- Reset values:
  - `div_cnt`=0, `sel`=0, both banks all zero, FSM IDLE.
  - `commit_pending`=0, `commit_done`=0, `frame_tick`=0.
  - `num`=0; `blank`=~`digit_en`[0].
- Reset asserted mid-frame or mid-commit clears everything immediately, without waiting for a clock edge. A commit armed before reset is discarded.
- Each digit is shown for exactly CLK_DIV cycles. A frame is 8×CLK_DIV cycles.
- The first `slot_tick` after reset release comes at cycle CLK_DIV-1.
- Commit latency: between 1 and 8×CLK_DIV cycles after `commit_req`, measured to the edge where `sel` becomes 0.
- A write is visible on `num` no earlier than the first frame after the commit that follows it.
- `digit_en` changes affect `blank` in the same cycle.

## Test plan
1. Reset, CLK_DIV=4, `digit_en`=8'hFF, no writes.
   - `sel` steps 0,1,…,7,0, holding 4 cycles each.
   - `num`=0 throughout, `blank`=0.
   - `frame_tick` pulses every 32 cycles.
2. Write shadow[i]=i+8 for i=0..7, pulse `commit_req` while `sel`=3.
   - `commit_pending` goes 1.
   - `num` stays 0 until the wrap, then reads 8,9,…,F for `sel` 0..7.
   - `commit_done` and `frame_tick` pulse together once.
3. Write shadow[5]=4'hA with `commit_req` high on the exact wrap edge.
   - The copy shows the old shadow[5]; `commit_pending` stays 1.
   - The next frame shows 4'hA at `sel`=5; a second `commit_done` pulse occurs.
4. `digit_en`=8'b1010_1010.
   - `blank`=1 when `sel` is even, 0 when odd; `num` is unaffected.
   - Toggle `digit_en`[2] while `sel`=2: `blank` follows in the same cycle.
5. Pulse `commit_req` at `sel`=6, then assert `rst` for 1 cycle at `sel`=7.
   - All outputs return to reset values asynchronously.
   - No `commit_done`; active bank stays all zero after release.
6. CLK_DIV=1.
   - `sel` increments every cycle; `frame_tick` every 8 cycles.
   - A commit requested at `sel`=7 is applied on the very next edge.
